writeback_stage: RTL and testbench

//  Final stage of the rvga 5-stage pipeline; consumes the memory->writeback pipeline register.

---
 rtl/rvga_types_pkg.sv | 11 +
 rtl/rvga_cword_if.sv | 10 +
 rtl/writeback_stage_load_align.sv | 36 +++
 rtl/writeback_stage.sv | 143 ++++++++++++++
 tb/tb_writeback_stage.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/rvga_types_pkg.sv
// Shared rvga types: load-op encoding, writeback FSM states, register/word aliases.
package rvga_types;

   typedef logic [4:0]  rvga_reg;
   typedef logic [31:0] rvga_word;

   typedef enum logic [2:0] {LD_NONE, LB, LH, LW, LBU, LHU} rvga_ldop_e;

   typedef enum logic {IDLE, WAIT_LOAD} wb_state_e;

endpackage

// File: rtl/rvga_cword_if.sv
// Decoded control word carried down the pipeline; writeback reads rd_w_v and ldop.
interface rvga_cword_if;
   import rvga_types::*;

   logic       rd_w_v;
   rvga_ldop_e ldop;

   modport i (input rd_w_v, input ldop);
   modport o (output rd_w_v, output ldop);
endinterface

// File: rtl/writeback_stage_load_align.sv
// Selects and extends the addressed byte/half of a load word; flags misaligned accesses.
module load_align
   import rvga_types::*;
(
   input  rvga_ldop_e  ldop,
   input  logic [1:0]  offset,
   input  logic [31:0] rdata,
   output logic [31:0] data,
   output logic        misaligned
);

   logic [7:0]  sel_byte;
   logic [15:0] sel_half;

   always_comb begin
      sel_byte   = rdata[{offset, 3'b000} +: 8];
      sel_half   = offset[1] ? rdata[31:16] : rdata[15:0];
      data       = rdata;
      misaligned = 1'b0;
      case (ldop)
         LB:  data = {{24{sel_byte[7]}}, sel_byte};
         LBU: data = {24'd0, sel_byte};
         LH: begin
            data       = {{16{sel_half[15]}}, sel_half};
            misaligned = offset[0];
         end
         LHU: begin
            data       = {16'd0, sel_half};
            misaligned = offset[0];
         end
         LW:      misaligned = (offset != 2'd0);
         default: data = rdata;
      endcase
   end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: merges load/ALU results, drives the register-file write port, counts retirements.
module writeback_stage
   import rvga_types::*;
#(
   parameter int INSTRET_W    = 64,
   parameter int LOAD_TIMEOUT = 256
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 memory_writeback_v,
   input  logic [4:0]           memory_writeback_rd,
   input  logic [31:0]          memory_writeback_result,
   rvga_cword_if.i              cword_i,
   input  logic                 load_rvalid_i,
   input  logic [31:0]          load_rdata_i,
   output logic                 stall_o,
   output logic                 rf_w_v_o,
   output logic [4:0]           rf_w_addr_o,
   output logic [31:0]          rf_w_data_o,
   output logic [INSTRET_W-1:0] instret_o,
   output logic                 load_err_o
);

   localparam int CNT_W = $clog2(LOAD_TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOAD_TIMEOUT - 1);

   wb_state_e        state, state_nxt;
   logic [CNT_W-1:0] wait_cnt;
   rvga_reg          cap_rd;
   logic             cap_rdv;
   rvga_ldop_e       cap_ldop;
   logic [1:0]       cap_off;

   rvga_ldop_e al_ldop;
   logic [1:0] al_off;
   rvga_word   al_data;
   logic       al_mis;
   logic       is_load;

   logic       commit_p0, err_p0, rdv_p0, wr_p0;
   rvga_reg    rd_p0;
   rvga_word   data_p0;
   logic       cap_en, cnt_clr, cnt_inc;

   // While waiting, alignment runs on the captured op/offset, not the (held) upstream fields.
   assign al_ldop = (state == WAIT_LOAD) ? cap_ldop : cword_i.ldop;
   assign al_off  = (state == WAIT_LOAD) ? cap_off  : memory_writeback_result[1:0];
   assign is_load = memory_writeback_v & (cword_i.ldop != LD_NONE);

   load_align u_load_align (
      .ldop       (al_ldop),
      .offset     (al_off),
      .rdata      (load_rdata_i),
      .data       (al_data),
      .misaligned (al_mis)
   );

   always_comb begin
      state_nxt = state;
      stall_o   = 1'b0;
      commit_p0 = 1'b0;
      err_p0    = 1'b0;
      rd_p0     = memory_writeback_rd;
      rdv_p0    = cword_i.rd_w_v;
      data_p0   = memory_writeback_result;
      cap_en    = 1'b0;
      cnt_clr   = 1'b0;
      cnt_inc   = 1'b0;
      case (state)
         IDLE: begin
            if (memory_writeback_v) begin
               if (!is_load) begin
                  commit_p0 = 1'b1;
               end else if (al_mis) begin
                  commit_p0 = 1'b1;
                  err_p0    = 1'b1;
               end else if (load_rvalid_i) begin
                  commit_p0 = 1'b1;
                  data_p0   = al_data;
               end else begin
                  stall_o   = 1'b1;
                  cap_en    = 1'b1;
                  cnt_clr   = 1'b1;
                  state_nxt = WAIT_LOAD;
               end
            end
         end
         WAIT_LOAD: begin
            rd_p0  = cap_rd;
            rdv_p0 = cap_rdv;
            if (load_rvalid_i) begin
               commit_p0 = 1'b1;
               data_p0   = al_data;
               state_nxt = IDLE;
            end else if (wait_cnt == CNT_LAST) begin
               commit_p0 = 1'b1;
               err_p0    = 1'b1;
               state_nxt = IDLE;
            end else begin
               stall_o = 1'b1;
               cnt_inc = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
      wr_p0 = commit_p0 & rdv_p0 & (rd_p0 != 5'd0) & ~err_p0;
   end

   // Stage boundary: commit decision -> register-file write port and retirement counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         wait_cnt    <= '0;
         cap_rd      <= '0;
         cap_rdv     <= 1'b0;
         cap_ldop    <= LD_NONE;
         cap_off     <= 2'd0;
         rf_w_v_o    <= 1'b0;
         rf_w_addr_o <= '0;
         rf_w_data_o <= '0;
         instret_o   <= '0;
         load_err_o  <= 1'b0;
      end else begin
         state    <= state_nxt;
         rf_w_v_o <= wr_p0;
         if (wr_p0) begin
            rf_w_addr_o <= rd_p0;
            rf_w_data_o <= data_p0;
         end
         if (commit_p0) instret_o <= instret_o + INSTRET_W'(1);
         if (err_p0) load_err_o <= 1'b1;
         if (cnt_clr) wait_cnt <= '0;
         else if (cnt_inc) wait_cnt <= wait_cnt + CNT_W'(1);
         if (cap_en) begin
            cap_rd   <= memory_writeback_rd;
            cap_rdv  <= cword_i.rd_w_v;
            cap_ldop <= cword_i.ldop;
            cap_off  <= memory_writeback_result[1:0];
         end
      end
   end

endmodule

// File: tb/tb_writeback_stage.sv
// Directed plus randomized bench for writeback_stage with a transaction-level reference model.
module tb_writeback_stage;
   import rvga_types::*;

   localparam int T = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        mv;
   logic [4:0]  mrd;
   logic [31:0] mres;
   logic        lrv;
   logic [31:0] lrd;
   logic        stall_o, rf_w_v_o, load_err_o;
   logic [4:0]  rf_w_addr_o;
   logic [31:0] rf_w_data_o;
   logic [63:0] instret_o;

   rvga_cword_if cw();

   writeback_stage #(.INSTRET_W(64), .LOAD_TIMEOUT(T)) dut (
      .clk                     (clk),
      .rst                     (rst),
      .memory_writeback_v      (mv),
      .memory_writeback_rd     (mrd),
      .memory_writeback_result (mres),
      .cword_i                 (cw),
      .load_rvalid_i           (lrv),
      .load_rdata_i            (lrd),
      .stall_o                 (stall_o),
      .rf_w_v_o                (rf_w_v_o),
      .rf_w_addr_o             (rf_w_addr_o),
      .rf_w_data_o             (rf_w_data_o),
      .instret_o               (instret_o),
      .load_err_o              (load_err_o)
   );

   always #5 clk = ~clk;

   int          n_vec = 0;
   int          n_err = 0;
   logic [63:0] m_instret;
   logic        m_err;
   logic [4:0]  m_addr;
   logic [31:0] m_data;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference extraction: shift the addressed element to the bottom, then extend.
   function automatic logic [31:0] ref_load(input rvga_ldop_e op, input logic [1:0] off,
                                            input logic [31:0] w);
      logic [31:0] b, h;
      b = w >> (8 * int'(off));
      h = w >> (16 * int'(off[1]));
      case (op)
         LB:      return 32'($signed(b[7:0]));
         LBU:     return 32'(b[7:0]);
         LH:      return 32'($signed(h[15:0]));
         LHU:     return 32'(h[15:0]);
         default: return w;
      endcase
   endfunction

   task automatic scramble();
      mv        = 1'($urandom);
      mrd       = 5'($urandom);
      mres      = $urandom;
      cw.rd_w_v = 1'($urandom);
      cw.ldop   = rvga_ldop_e'(3'($urandom_range(0, 5)));
   endtask

   task automatic check_regs(input string tag);
      chk({tag, ".addr"}, 64'(rf_w_addr_o), 64'(m_addr));
      chk({tag, ".data"}, 64'(rf_w_data_o), 64'(m_data));
      chk({tag, ".instret"}, instret_o, m_instret);
      chk({tag, ".err"}, 64'(load_err_o), 64'(m_err));
   endtask

   task automatic idle(input string tag);
      mv  = 1'b0;
      lrv = 1'($urandom);
      lrd = $urandom;
      @(negedge clk);
      chk({tag, ".idle_stall"}, 64'(stall_o), 64'(0));
      @(posedge clk); #1;
      chk({tag, ".idle_wv"}, 64'(rf_w_v_o), 64'(0));
      check_regs({tag, ".idle"});
   endtask

   // k: cycles until load response (0 = same cycle), negative = never arrives.
   task automatic run_instr(input string tag, input logic rdv, input logic [4:0] rd,
                            input rvga_ldop_e op, input logic [31:0] res,
                            input logic [31:0] rdata, input int k);
      bit is_load, mis, tmo, wr;
      int stalls;
      is_load = (op != LD_NONE);
      mis     = ((op == LH || op == LHU) && res[0]) || (op == LW && res[1:0] != 2'd0);
      tmo     = is_load && !mis && (k < 0 || k > T);
      stalls  = (is_load && !mis && k != 0) ? (tmo ? T : k) : 0;
      for (int c = 0; c <= stalls; c++) begin
         if (c == 0) begin
            mv = 1'b1; mrd = rd; mres = res; cw.rd_w_v = rdv; cw.ldop = op;
         end else begin
            scramble();
         end
         lrv = is_load ? (k >= 0 && c == k) : 1'($urandom);
         lrd = lrv ? rdata : $urandom;
         @(negedge clk);
         chk({tag, ".stall"}, 64'(stall_o), 64'(c < stalls));
         if (c > 0) begin
            chk({tag, ".wait_wv"}, 64'(rf_w_v_o), 64'(0));
            chk({tag, ".wait_instret"}, instret_o, m_instret);
         end
         @(posedge clk); #1;
      end
      wr = rdv && (rd != 5'd0) && !mis && !tmo;
      m_instret = m_instret + 64'd1;
      if (mis || tmo) m_err = 1'b1;
      if (wr) begin
         m_addr = rd;
         m_data = is_load ? ref_load(op, res[1:0], rdata) : res;
      end
      chk({tag, ".wv"}, 64'(rf_w_v_o), 64'(wr));
      check_regs(tag);
   endtask

   initial begin
      rst = 1'b1; mv = 1'b0; mrd = '0; mres = '0; lrv = 1'b0; lrd = '0;
      cw.rd_w_v = 1'b0; cw.ldop = LD_NONE;
      m_instret = '0; m_err = 1'b0; m_addr = '0; m_data = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset.wv", 64'(rf_w_v_o), 64'(0));
      check_regs("reset");
      @(negedge clk);
      chk("reset.stall", 64'(stall_o), 64'(0));
      @(posedge clk); #1;
      rst = 1'b0;

      run_instr("t1_lb", 1'b1, 5'd5, LB, 32'h0000_1003, 32'h8011_2233, 0);
      idle("t1");
      run_instr("t2_lhu", 1'b1, 5'd7, LHU, 32'h0000_2002, 32'hBEEF_1234, 3);
      idle("t2");
      run_instr("t3_add", 1'b1, 5'd0, LD_NONE, 32'h0000_1234, 32'h0, 0);
      run_instr("t4_lw_mis", 1'b1, 5'd9, LW, 32'h0000_3001, 32'hCAFE_F00D, 0);
      idle("t4");
      run_instr("t5_tmo", 1'b1, 5'd11, LW, 32'h0000_4000, 32'h1111_2222, -1);
      idle("t5");
      run_instr("t5b_edge", 1'b1, 5'd12, LH, 32'h0000_4002, 32'h8001_7FFF, T);

      // Reset while a load is outstanding, then a stray response.
      mv = 1'b1; mrd = 5'd13; mres = 32'h0000_5000; cw.rd_w_v = 1'b1; cw.ldop = LW; lrv = 1'b0;
      @(negedge clk);
      chk("t6.stall", 64'(stall_o), 64'(1));
      @(posedge clk); #1;
      mv = 1'b0; rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; lrv = 1'b1; lrd = 32'hDEAD_BEEF;
      m_instret = '0; m_err = 1'b0; m_addr = '0; m_data = '0;
      chk("t6.rst_wv", 64'(rf_w_v_o), 64'(0));
      check_regs("t6.rst");
      @(negedge clk);
      chk("t6.stray_stall", 64'(stall_o), 64'(0));
      @(posedge clk); #1;
      chk("t6.stray_wv", 64'(rf_w_v_o), 64'(0));
      check_regs("t6.stray");

      for (int i = 0; i < 300; i++) begin
         int k;
         k = int'($urandom_range(0, 7));
         if (k == 7) k = -1;
         run_instr("rand", 1'($urandom), 5'($urandom),
                   rvga_ldop_e'(3'($urandom_range(0, 5))), $urandom, $urandom, k);
         if ($urandom_range(0, 3) == 0) idle("rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
